// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_e;

    // An access is misaligned if it does not sit on its natural boundary.
    // The reserved size encoding is rejected the same way.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size_e'(size))
            SIZE_B:  return 1'b0;
            SIZE_H:  return addr_lo[0];
            SIZE_W:  return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extraction/extension for loads, read-modify-write merge for stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed byte and half-word lanes of the memory word.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_lane = word[7:0];
            2'b01:   byte_lane = word[15:8];
            2'b10:   byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Right-align the lane and extend using its MSB unless zero-extension is requested.
    always_comb begin
        case (size_e'(size))
            SIZE_B:  load_data = {{24{byte_lane[7] & ~uns}}, byte_lane};
            SIZE_H:  load_data = {{16{half_lane[15] & ~uns}}, half_lane};
            default: load_data = word;
        endcase
    end

    // Replace only the targeted lane of the word read back from memory.
    always_comb begin
        merge_data = word;
        case (size_e'(size))
            SIZE_B: begin
                case (addr_lo)
                    2'b00:   merge_data[7:0]   = wdata[7:0];
                    2'b01:   merge_data[15:8]  = wdata[7:0];
                    2'b10:   merge_data[23:16] = wdata[7:0];
                    default: merge_data[31:24] = wdata[7:0];
                endcase
            end
            SIZE_H: begin
                if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
                else            merge_data[15:0]  = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: adapts byte/half/word core requests to a word-only memory port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    // Timeout fires on the cycle whose missing ack would bring the count to ACK_TIMEOUT.
    localparam bit          TIMEOUT_EN   = (ACK_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = (ACK_TIMEOUT == 0) ? 32'd0 : 32'(ACK_TIMEOUT - 1);

    state_e      state, state_next;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, wword_q, rdata_q, cnt_q;
    logic        accept, misaligned, timeout;
    logic [31:0] load_data, merge_data;

    assign accept     = req_valid_i && req_ready_o;
    assign misaligned = is_misaligned(req_size_i, req_addr_i[1:0]);
    assign timeout    = TIMEOUT_EN && !mem_ack_i && (cnt_q == TIMEOUT_LAST);

    lsu_lane_align u_align (
        .word       (mem_data_i),
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .uns        (uns_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decision: sub-word stores read first so the untouched lanes survive.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)                                  state_next = RESP;
                    else if (req_we_i && size_e'(req_size_i) == SIZE_W) state_next = WR;
                    else                                             state_next = RD;
                end
            end
            RD: begin
                if (mem_ack_i)    state_next = we_q ? WR : RESP;
                else if (timeout) state_next = RESP;
            end
            WR: begin
                if (mem_ack_i || timeout) state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and memory strobes; strobes are gated by reset so a reset edge never commits a write.
    always_comb begin
        req_ready_o = (state == IDLE) && !rst;
        rsp_valid_o = (state == RESP) && !rst;
        mem_rd_en_o = (state == RD)   && !rst;
        mem_wr_en_o = (state == WR)   && !rst;
    end

    // Request capture, merge word, response data/error and ack-wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we_i;
                        uns_q   <= req_unsigned_i;
                        size_q  <= req_size_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        wword_q <= req_wdata_i;
                        cnt_q   <= '0;
                        if (misaligned) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                RD: begin
                    if (mem_ack_i) begin
                        cnt_q <= '0;
                        if (we_q) begin
                            wword_q <= merge_data;
                        end else begin
                            rdata_q <= load_data;
                            err_q   <= 1'b0;
                        end
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                WR: begin
                    if (mem_ack_i) begin
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_data_o  = wword_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array style reference model plus a word memory model.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_rd_en, mem_wr_en, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        to_valid, to_ready, to_rsp_valid, to_rsp_err, to_rd_en, to_wr_en, to_ack;
    logic [31:0] to_rsp_rdata, to_mem_addr, to_mem_wdata, to_mem_rdata;
    assign to_ack       = 1'b0;
    assign to_mem_rdata = 32'h0;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata),
        .mem_ack_i(mem_ack)
    );

    load_store_unit #(.ACK_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid_i(to_valid), .req_ready_o(to_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(to_rsp_valid), .rsp_rdata_o(to_rsp_rdata),
        .rsp_err_o(to_rsp_err), .mem_rd_en_o(to_rd_en), .mem_wr_en_o(to_wr_en),
        .mem_addr_o(to_mem_addr), .mem_data_o(to_mem_wdata), .mem_data_i(to_mem_rdata),
        .mem_ack_i(to_ack)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic        mem_init, hold_wr;
    int unsigned stall, stall_load;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h8899AABB;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            stall <= 0;
        end else begin
            if (mem_wr_en && mem_ack) mem[mem_addr[7:2]] <= mem_wdata;
            if (req_valid && req_ready) stall <= stall_load;
            else if ((mem_rd_en || mem_wr_en) && stall != 0) stall <= stall - 1;
        end
    end

    assign mem_ack   = (stall == 0) && !(hold_wr && mem_wr_en);
    assign mem_rdata = mem[mem_addr[7:2]];

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] cur_waddr  = 32'h0;
    bit          cur_err    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: memory viewed as bytes; a request touches 2**size bytes starting at addr.
    task automatic model_push(input bit we, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int st, output bit err);
        exp_t              e;
        int                nb, off, idx;
        longint unsigned   mask, v, w;
        off = int'(addr % 4);
        idx = int'((addr / 4) % 64);
        err = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0);
        if (err) begin
            e.rdata = 32'h0; e.err = 1'b1; e.lat = 1;
        end else begin
            nb   = 1 << size;
            mask = (64'd1 << (8 * nb)) - 1;
            w    = ref_mem[idx];
            if (!we) begin
                v = (w >> (8 * off)) & mask;
                if (!uns && ((v >> (8 * nb - 1)) & 1) != 0) v = v | (64'hFFFF_FFFF & ~mask);
                e.rdata = v[31:0]; e.err = 1'b0; e.lat = 2 + st;
            end else begin
                v = (w & ~(mask << (8 * off))) | ((longint'(wdata) & mask) << (8 * off));
                ref_mem[idx] = v[31:0];
                e.rdata = 32'h0; e.err = 1'b0; e.lat = ((nb == 4) ? 2 : 3) + st;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: checks every response, the memory address of every access, and rdata hold.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_rdata = 32'h0;
        end else begin
            if (req_valid && req_ready) acc_cyc = cyc;
            if (mem_rd_en || mem_wr_en) begin
                check("mem_addr", mem_addr, cur_waddr);
                check("no_access_on_err", 32'(cur_err), 32'd0);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, expected none (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    check("latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
                    last_rdata = mon_e.rdata;
                end
            end else begin
                check("rdata_hold", rsp_rdata, last_rdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int st);
        bit err;
        @(posedge clk); #1;
        model_push(we, size, uns, addr, wdata, st, err);
        cur_err      = err;
        cur_waddr    = addr & 32'hFFFF_FFFC;
        stall_load   = st;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: got no response, expected one within 40 cycles");
            exp_q.delete();
        end
    endtask

    // Timed-out request on the ACK_TIMEOUT=4 instance, whose ack is tied low.
    task automatic to_run(input bit we, input logic [1:0] size, input logic [31:0] addr,
                          input int exp_rd, input int exp_wr);
        int rd_n, wr_n, lat;
        bit got;
        rd_n = 0; wr_n = 0; lat = 0; got = 1'b0;
        @(posedge clk); #1;
        req_we = we; req_size = size; req_unsigned = 1'b0; req_addr = addr;
        req_wdata = 32'hCAFE_F00D; to_valid = 1'b1;
        @(posedge clk); #1;
        to_valid = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (to_rd_en) rd_n++;
            if (to_wr_en) wr_n++;
            if (to_rsp_valid) begin
                got = 1'b1;
                lat = k;
                check("to_err", 32'(to_rsp_err), 32'd1);
                check("to_rdata", to_rsp_rdata, 32'h0);
            end
        end
        check("to_rsp_seen", 32'(got), 32'd1);
        check("to_latency", 32'(lat), 32'd5);
        check("to_rd_cycles", 32'(rd_n), 32'(exp_rd));
        check("to_wr_cycles", 32'(wr_n), 32'(exp_wr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst = 1'b1; mem_init = 1'b1; hold_wr = 1'b0; stall_load = 0;
        req_valid = 1'b0; to_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_rsp_rdata", rsp_rdata,      32'h0);
        check("rst_mem_addr",  mem_addr,       32'h0);
        check("rst_mem_data",  mem_wdata,      32'h0);
        check("rst_ready",     32'(req_ready), 32'd0);
        check("rst_mem_en",    32'({mem_rd_en, mem_wr_en}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Loads from the preloaded word at 0x10.
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
        issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0);

        // Reset while a byte store to 0x10 is waiting in WR.
        @(posedge clk); #1;
        hold_wr = 1'b1; stall_load = 0; cur_err = 1'b0; cur_waddr = 32'h10;
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h10;
        req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem_wr_en;
        end
        check("wr_phase_reached", 32'(seen), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; hold_wr = 1'b0;
        @(negedge clk);
        check("wr_en_gated_by_rst", 32'(mem_wr_en), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_midop_rst", 32'(req_ready), 32'd1);
        check("no_rsp_after_midop_rst", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("word_unchanged", mem[4], ref_mem[4]);

        // Stores, read-back, and errors.
        issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0055, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
        issue(1'b1, 2'd1, 1'b0, 32'h13, 32'hFFFF, 0);

        // Ack stalls on the wait-forever instance.
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 6);
        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h0BAD_F00D, 3);
        issue(1'b1, 2'd0, 1'b0, 32'h32, 32'hA5, 2);

        // Timeouts on the ACK_TIMEOUT=4 instance.
        to_run(1'b0, 2'd2, 32'h40, 4, 0);
        to_run(1'b1, 2'd2, 32'h44, 0, 4);
        to_run(1'b1, 2'd1, 32'h46, 4, 0);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), $urandom, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 64; i++) check("mem_word", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Bus master sitting directly upstream of the data memory; converts core load/store requests (byte, half, word; signed/unsigned) into the memory's word-only interface (rd_en/wr_en, addr, data, ack).
- Performs word-lane extraction with sign/zero extension for loads.
- Performs read-modify-write for sub-word stores, because the memory writes full 32-bit words only.
- Detects misalignment and ack timeout.

Parameters:
ACK_TIMEOUT, 0, cycles to wait for mem_ack_i in RD/WR before aborting with error; 0 = wait forever

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  unit can accept request (high in IDLE)
req_we_i  input  1  1 = store, 0 = load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid_o  output  1  one-cycle pulse, transaction complete
rsp_rdata_o  output  32  extended load data; 0 for stores/errors; held until next rsp
rsp_err_o  output  1  valid with rsp_valid_o; misaligned, illegal size or timeout
mem_rd_en_o  output  1  to memory rd_en_i
mem_wr_en_o  output  1  to memory wr_en_i
mem_addr_o  output  32  word-aligned address (addr[1:0] = 00)
mem_data_o  output  32  write word
mem_data_i  input  32  read word from memory
mem_ack_i  input  1  memory acknowledge

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset state is IDLE. Reset values: rsp_valid_o 0, rsp_err_o 0, rsp_rdata_o 0, mem_addr_o 0, mem_data_o 0.
- mem_rd_en_o and mem_wr_en_o are gated with ~rst, so no memory write commits on a reset edge.
- While rst is high, no request is accepted.
- IDLE:
  - req_ready_o = 1. Accept on req_valid_i & req_ready_o; latch we, size, unsigned, addr, wdata.
  - Misaligned request: half with addr[0] = 1, word with addr[1:0] != 00, or size 11 -> RESP with err = 1. No memory access.
  - Aligned load or aligned sub-word store -> RD.
  - Aligned word store -> WR.
- RD:
  - mem_rd_en_o = 1, mem_addr_o = {addr[31:2], 2'b00}.
  - On mem_ack_i, capture mem_data_i.
  - Load -> RESP; rdata = lane selected by addr[1:0], extended per size/unsigned.
  - Sub-word store -> WR; merge word = captured word with target byte/half replaced by wdata low bits.
- WR:
  - mem_wr_en_o = 1; mem_data_o = merge word, or wdata for a word store.
  - Write commits on the edge where mem_ack_i = 1 -> RESP.
- RESP:
  - rsp_valid_o = 1 for exactly one cycle, then IDLE.
  - req_ready_o = 0 in RD, WR and RESP; a new request is accepted no earlier than the cycle after RESP.
- Latency with ack tied high, counted from the accept edge to the rsp_valid_o cycle:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
  - Each ack-low cycle adds one cycle.
- Timeout (ACK_TIMEOUT > 0):
  - Counter clears on entry to RD/WR and increments each cycle without ack.
  - When the counter reaches ACK_TIMEOUT -> RESP with err = 1, rdata = 0; no write-enable beyond that cycle.
- Lane rules, loads:
  - Byte: lane = addr[1:0]; bits [8k+7:8k], k = lane.
  - Half: addr[1] selects [31:16] or [15:0].
  - Sign extension uses the lane MSB.
- Reset mid-operation: transaction abandoned, no rsp pulse, no partial write; IDLE with req_ready_o = 1 on the cycle after rst drops.

Decomposition:
- Package lsu_pkg: size encodings (SIZE_B, SIZE_H, SIZE_W), state enum, misalignment function.
- Sub-module lsu_lane_align (combinational): extract + extend for loads, merge for stores. Inputs: word, addr[1:0], size, unsigned, wdata.

Test Plan:
- Preload word at 0x10 = 0x8899AABB.
  - Signed byte load at 0x13 -> rdata 0xFFFFFF88.
  - Unsigned byte load at 0x13 -> 0x00000088.
  - Signed half load at 0x10 -> 0xFFFFAABB.
  - rsp_valid_o 2 cycles after accept.
- Half store 0x00001234 to 0x12 (memory word at 0x10 = 0x8899AABB) -> memory word 0x1234AABB. Observe RD then WR with mem_addr_o = 0x10; rsp 3 cycles after accept, err = 0.
- Word store 0xDEADBEEF to 0x20, then word load 0x20 -> rdata 0xDEADBEEF. Byte store 0x55 to 0x21 -> word 0xDEAD55EF.
- Word load at 0x11 and size 11 at 0x10 -> rsp_valid_o next cycle, err = 1, rdata 0; mem_rd_en_o/mem_wr_en_o never high.
- Ack stalls:
  - ACK_TIMEOUT = 4, ack held low in RD -> err rsp after 4 RD cycles.
  - ACK_TIMEOUT = 0, ack low 2 cycles -> correct data, latency 4.
- rst asserted during WR of a byte store to 0x10 (word 0x8899AABB) -> word unchanged, no rsp_valid_o, req_ready_o = 1 the cycle after rst drops.
